// File: rtl/countdown_timer_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | countdown_timer_mux                                                        |
// | BCD MM:SS.cc countdown timer with 8-digit multiplexed 7-segment driver.    |
// | Optional feature macro: COUNTDOWN_WARN_EN (blink under 10 s while running) |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module countdown_timer_mux #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int INIT_MIN  = 30,
  parameter int SCAN_BITS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [6:0] load_min,
  output logic       running,
  output logic       game_over,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic [7:0] an
);

  localparam int             c_div       = CLK_HZ / TICK_HZ;
  localparam int             c_pw        = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_pw-1:0] c_pre_max  = c_pw'(c_div - 1);
  localparam logic [3:0]     c_init_m1   = 4'(INIT_MIN / 10);
  localparam logic [3:0]     c_init_m0   = 4'(INIT_MIN % 10);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_run     = 2'd1;
  localparam logic [1:0] c_st_pause   = 2'd2;
  localparam logic [1:0] c_st_expired = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [3:0]           r_m1, r_m0, r_s1, r_s0, r_c1, r_c0;
  logic [c_pw-1:0]      r_pre;
  logic [SCAN_BITS-1:0] r_scan;
  logic                 r_start_q, r_pause_q, r_load_q;

  logic       w_start_e, w_pause_e, w_load_e;
  logic       w_tick, w_is_zero, w_is_one;
  logic       w_load_time, w_do_dec, w_pre_clr;
  logic [6:0] w_lmin_cl;
  logic [3:0] w_ld_m1, w_ld_m0;
  logic [3:0] w_d_m1, w_d_m0, w_d_s1, w_d_s0, w_d_c1, w_d_c0;
  logic       w_b_c1, w_b_s0, w_b_s1, w_b_m0, w_b_m1;

  function automatic logic [3:0] bcd_dec(input logic [3:0] dig, input logic bin,
                                         input logic [3:0] top);
    if (!bin)
      return dig;
    return (dig == 4'd0) ? top : dig - 4'd1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] dig);
    case (dig)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  assign w_start_e = start & ~r_start_q;
  assign w_pause_e = pause & ~r_pause_q;
  assign w_load_e  = load & ~r_load_q;

  assign w_tick    = (r_state == c_st_run) && (r_pre == c_pre_max);
  assign w_is_zero = ({r_m1, r_m0, r_s1, r_s0, r_c1, r_c0} == 24'h000000);
  assign w_is_one  = ({r_m1, r_m0, r_s1, r_s0, r_c1, r_c0} == 24'h000001);

  assign w_lmin_cl = (load_min > 7'd99) ? 7'd99 : load_min;
  assign w_ld_m1   = 4'(w_lmin_cl / 7'd10);
  assign w_ld_m0   = 4'(w_lmin_cl % 7'd10);

  // Borrow ripples up while the lower digit is at zero; seconds tens wrap to 5.
  assign w_b_c1 = (r_c0 == 4'd0);
  assign w_b_s0 = w_b_c1 & (r_c1 == 4'd0);
  assign w_b_s1 = w_b_s0 & (r_s0 == 4'd0);
  assign w_b_m0 = w_b_s1 & (r_s1 == 4'd0);
  assign w_b_m1 = w_b_m0 & (r_m0 == 4'd0);
  assign w_d_c0 = bcd_dec(r_c0, 1'b1, 4'd9);
  assign w_d_c1 = bcd_dec(r_c1, w_b_c1, 4'd9);
  assign w_d_s0 = bcd_dec(r_s0, w_b_s0, 4'd9);
  assign w_d_s1 = bcd_dec(r_s1, w_b_s1, 4'd5);
  assign w_d_m0 = bcd_dec(r_m0, w_b_m0, 4'd9);
  assign w_d_m1 = bcd_dec(r_m1, w_b_m1, 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    w_load_time = 1'b0;
    w_do_dec    = 1'b0;
    w_pre_clr   = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_load_e) begin
          w_load_time = 1'b1;
        end else if (w_start_e) begin
          if (w_is_zero) begin
            w_state_nxt = c_st_expired;
          end else begin
            w_state_nxt = c_st_run;
            w_pre_clr   = 1'b1;
          end
        end
      end
      c_st_run: begin
        if (w_tick) begin
          w_do_dec = 1'b1;
        end
        if (w_tick && w_is_one) begin
          w_state_nxt = c_st_expired;
        end else if (w_pause_e) begin
          w_state_nxt = c_st_pause;
        end
      end
      c_st_pause: begin
        if (w_load_e) begin
          w_load_time = 1'b1;
          w_state_nxt = c_st_idle;
        end else if (w_start_e) begin
          w_state_nxt = c_st_run;
          w_pre_clr   = 1'b1;
        end
      end
      c_st_expired: begin
        if (w_load_e) begin
          w_load_time = 1'b1;
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_st_idle;
      r_m1      <= c_init_m1;
      r_m0      <= c_init_m0;
      r_s1      <= 4'd0;
      r_s0      <= 4'd0;
      r_c1      <= 4'd0;
      r_c0      <= 4'd0;
      r_pre     <= '0;
      r_scan    <= '0;
      r_start_q <= 1'b0;
      r_pause_q <= 1'b0;
      r_load_q  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_scan    <= r_scan + SCAN_BITS'(1);
      r_start_q <= start;
      r_pause_q <= pause;
      r_load_q  <= load;
      if (w_pre_clr) begin
        r_pre <= '0;
      end else if (r_state == c_st_run) begin
        r_pre <= w_tick ? '0 : r_pre + c_pw'(1);
      end
      if (w_load_time) begin
        r_m1 <= w_ld_m1;
        r_m0 <= w_ld_m0;
        r_s1 <= 4'd0;
        r_s0 <= 4'd0;
        r_c1 <= 4'd0;
        r_c0 <= 4'd0;
      end else if (w_do_dec) begin
        r_m1 <= w_d_m1;
        r_m0 <= w_d_m0;
        r_s1 <= w_d_s1;
        r_s0 <= w_d_s0;
        r_c1 <= w_d_c1;
        r_c0 <= w_d_c0;
      end
    end
  end

  assign running   = (r_state == c_st_run);
  assign game_over = (r_state == c_st_expired);

  logic [2:0] w_k;
  logic [3:0] w_digit;
  logic [6:0] w_seg;
  logic       w_blank, w_dp, w_warn_off;

  assign w_k = r_scan[SCAN_BITS-1 -: 3];

  always_comb begin
    w_digit = 4'd0;
    case (w_k)
      3'd0:    w_digit = r_c0;
      3'd1:    w_digit = r_c1;
      3'd2:    w_digit = r_s0;
      3'd3:    w_digit = r_s1;
      3'd4:    w_digit = r_m0;
      3'd5:    w_digit = r_m1;
      default: w_digit = 4'd0;
    endcase
  end

  assign w_blank = (w_k == 3'd6) || (w_k == 3'd7);
  assign w_dp    = (w_k == 3'd2) || (w_k == 3'd4);
  assign w_seg   = w_blank ? 7'b0000000 : seg_decode(w_digit);

`ifdef COUNTDOWN_WARN_EN
  // Blank during the upper half of every second, giving a 1 Hz blink below 10 s.
  assign w_warn_off = (r_state == c_st_run) && (r_m1 == 4'd0) && (r_m0 == 4'd0) &&
                      (r_s1 == 4'd0) && (r_c1 >= 4'd5);
`else
  assign w_warn_off = 1'b0;
`endif

  assign {g, f, e, d, c, b, a} = w_warn_off ? 7'b0000000 : w_seg;
  assign dp = w_dp & ~w_warn_off;
  assign an = ~(8'd1 << w_k);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_countdown_timer_mux                                                     |
// | Scoreboard bench: display is read back digit by digit and decoded.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_countdown_timer_mux;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load  = 1'b0;
  logic [6:0] load_min = 7'd1;
  logic       running, game_over, a, b, c, d, e, f, g, dp;
  logic [7:0] an;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cs;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  countdown_timer_mux #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .INIT_MIN (1),
    .SCAN_BITS(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .load     (load),
    .load_min (load_min),
    .running  (running),
    .game_over(game_over),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .dp       (dp),
    .an       (an)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_t item;
    item.tag = tag;
    item.val = val;
    sb_q.push_back(item);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t item;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got 0x%0h expected nothing pending", act);
    end else begin
      item = sb_q.pop_front();
      check(item.tag, act, item.val);
    end
  endtask

  // Expected time from a plain centisecond count, independent of BCD arithmetic.
  function automatic logic [31:0] to_bcd(input int cs);
    int m, s, h;
    m = cs / 6000;
    s = (cs / 100) % 60;
    h = cs % 100;
    return {8'h00, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic [3:0] seg_to_dig(input logic [6:0] s);
    case (s)
      7'b0111111: return 4'd0;
      7'b0000110: return 4'd1;
      7'b1011011: return 4'd2;
      7'b1001111: return 4'd3;
      7'b1100110: return 4'd4;
      7'b1101101: return 4'd5;
      7'b1111101: return 4'd6;
      7'b0000111: return 4'd7;
      7'b1111111: return 4'd8;
      7'b1101111: return 4'd9;
      7'b1000000: return 4'hE;
      default:    return 4'hF;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic l);
    start = s;
    pause = p;
    load  = l;
    @(posedge clock);
    #1;
    start = 1'b0;
    pause = 1'b0;
    load  = 1'b0;
  endtask

  // One full scan: collect the six digits and verify an/dp/blank behaviour.
  task automatic read_time(output logic [31:0] t, output logic scan_ok);
    logic [3:0] dig [8];
    int k, prev_k;
    for (int i = 0; i < 8; i++) dig[i] = 4'hF;
    prev_k  = -1;
    scan_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      k = -1;
      for (int j = 0; j < 8; j++)
        if (an == ~(8'd1 << j)) k = j;
      if (k < 0) begin
        scan_ok = 1'b0;
      end else begin
        if (prev_k >= 0 && k != (prev_k + 1) % 8) scan_ok = 1'b0;
        prev_k = k;
        if (dp !== ((k == 2) || (k == 4))) scan_ok = 1'b0;
        if (k >= 6) begin
          if ({g, f, e, d, c, b, a} != 7'b0) scan_ok = 1'b0;
        end else begin
          dig[k] = seg_to_dig({g, f, e, d, c, b, a});
        end
      end
    end
    t = {8'h00, dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
    @(posedge clock);
    #1;
  endtask

  task automatic read_lit(output logic any_lit);
    any_lit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if ({g, f, e, d, c, b, a, dp} != 8'b0) any_lit = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic expect_time(input string tag);
    logic [31:0] t;
    logic        ok;
    sb_push(tag, to_bcd(exp_cs));
    read_time(t, ok);
    sb_pop(t);
    check({tag, "_scan"}, 32'(ok), 32'd1);
  endtask

  // Start, run exactly n ticks, and pause on the edge of the n-th tick.
  task automatic run_ticks(input int n);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(10 * n - 1);
    pulse(1'b0, 1'b1, 1'b0);
    exp_cs -= n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lit;
    wait_cycles(2);
    check("rst_an", 32'(an), 32'h0FE);
    check("rst_running", 32'(running), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_seg", 32'({g, f, e, d, c, b, a}), 32'b0111111);
    check("rst_dp", 32'(dp), 32'd0);
    reset = 1'b1;
    exp_cs = 6000;
    expect_time("reset_time");

    // Pause one cycle before the first tick is due: nothing decremented yet.
    pulse(1'b1, 1'b0, 1'b0);
    check("start_running", 32'(running), 32'd1);
    wait_cycles(8);
    pulse(1'b0, 1'b1, 1'b0);
    check("pause9_running", 32'(running), 32'd0);
    expect_time("pause_before_tick");

    load_min = 7'd1;
    pulse(1'b0, 1'b0, 1'b1);
    exp_cs = 6000;
    run_ticks(1);
    expect_time("first_tick");
    run_ticks(24);
    expect_time("after_25_ticks");
    wait_cycles(1000);
    expect_time("frozen_1000");
    run_ticks(1);
    expect_time("resume_tick");

    // Load beats start on the same edge, in PAUSE and in IDLE.
    load_min = 7'd120;
    pulse(1'b1, 1'b0, 1'b1);
    exp_cs = 99 * 6000;
    check("pause_load_start_running", 32'(running), 32'd0);
    expect_time("clamp_99");
    load_min = 7'd5;
    pulse(1'b1, 1'b0, 1'b1);
    exp_cs = 5 * 6000;
    check("idle_load_start_running", 32'(running), 32'd0);
    expect_time("load_5");

    load_min = 7'd0;
    pulse(1'b0, 1'b0, 1'b1);
    exp_cs = 0;
    pulse(1'b1, 1'b0, 1'b0);
    check("zero_start_game_over", 32'(game_over), 32'd1);
    check("zero_start_running", 32'(running), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check("expired_start_ignored", 32'({running, game_over}), 32'b01);

    load_min = 7'd1;
    pulse(1'b0, 1'b0, 1'b1);
    exp_cs = 6000;
    check("reload_game_over", 32'(game_over), 32'd0);
    run_ticks(1488);
    expect_time("t_45_12");
    run_ticks(3942);
    expect_time("t_05_70");

    pulse(1'b1, 1'b0, 1'b0);
    read_lit(lit);
`ifdef COUNTDOWN_WARN_EN
    sb_push("warn_blank", 32'd0);
`else
    sb_push("warn_steady", 32'd1);
`endif
    sb_pop(32'(lit));
    wait_cycles(1);
    pulse(1'b0, 1'b1, 1'b0);
    exp_cs -= 1;
    expect_time("t_05_69");
    run_ticks(566);
    expect_time("t_00_03");

    // Ticks land on R10, R20, R30; the third reaches zero and expires.
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(29);
    check("pre_expiry", 32'({running, game_over}), 32'b10);
    wait_cycles(1);
    check("expiry", 32'({running, game_over}), 32'b01);
    exp_cs = 0;
    expect_time("expired_zero");
    wait_cycles(1000);
    expect_time("expired_hold");
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("expired_ignore", 32'({running, game_over}), 32'b01);
    load_min = 7'd7;
    pulse(1'b0, 1'b0, 1'b1);
    exp_cs = 7 * 6000;
    check("expired_load", 32'({running, game_over}), 32'b00);
    expect_time("load_7");

    // Asynchronous reset in the middle of a clock period while running.
    load_min = 7'd1;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cycles(55);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_an", 32'(an), 32'h0FE);
    check("async_running", 32'(running), 32'd0);
    check("async_seg", 32'({g, f, e, d, c, b, a}), 32'b0111111);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_cs = 6000;
    expect_time("after_async_reset");
    run_ticks(1);
    expect_time("post_reset_tick");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
